xalu: RTL

Multiply/divide unit with HI/LO registers, sitting in the EX stage beside the main ALU. Executes the `XALUOp` command issued by the instruction decoder (mult, multu, div, divu, mthi, mtlo, mfhi, mflo). Runs multi-cycle multiply and divide behind a `busy` handshake that the hazard unit uses to stall dependent HI/LO instructions.

---
 rtl/xalu_pkg.sv | 33 +++
 rtl/xalu_if.sv | 26 ++
 rtl/xalu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the multiply/divide unit and the instruction decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: XALUOp command codes, default multi-cycle latencies, FSM state
// type and a two's-complement negate helper used by the signed divider.
package xalu_pkg;

    // XALUOp command codes; 9..15 decode as NONE.
    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] MTHI  = 4'd3;
    localparam logic [3:0] MTLO  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] DIV   = 4'd7;
    localparam logic [3:0] DIVU  = 4'd8;

    // Default busy durations; the 4-bit counter limits both to 1..15.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/xalu_if.sv
// Command/result bundle between the EX-stage decoder and the XALU.
// Latency: n/a (wires only).
// Backpressure: busy tells the hazard unit to stall HI/LO users.
//
// Signals: start (valid command), XALUOp (command), A/B (rs/rt operands),
// busy (mult/div in flight), out (mfhi/mflo read data), HI/LO (architectural).
interface xalu_if;
    logic        start;
    logic [3:0]  XALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, XALUOp, A, B,
        input  busy, out, HI, LO
    );

    modport slave (
        input  start, XALUOp, A, B,
        output busy, out, HI, LO
    );
endinterface

// File: rtl/xalu.sv
// Multiply/divide unit owning HI/LO; mult/div run multi-cycle, mthi/mtlo/mfhi/mflo are immediate.
// Latency: mult MULT_CYCLES, div DIV_CYCLES to HI/LO commit; mthi/mtlo 1 cycle; mfhi/mflo 0 cycles.
// Backpressure: busy is high while a mult/div is pending; commands arriving while busy are dropped.
//
// Ports: clk, reset (async, active-high), bus (xalu_if.slave: start, XALUOp,
// A, B in; busy, out, HI, LO out).
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   reset,
    xalu_if.slave  bus
);

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;
    logic [31:0] r_p_hi,  w_p_hi_nxt;
    logic [31:0] r_p_lo,  w_p_lo_nxt;
    logic        r_dz,    w_dz_nxt;     // pending divide had a zero divisor

    // ---------------- Arithmetic, evaluated on the start cycle ----------------
    logic [63:0] w_prod_s, w_prod_u;
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    logic        w_b_zero;
    logic [31:0] w_div_u, w_quo_u, w_rem_u;
    assign w_b_zero = (bus.B == 32'd0);
    // Substitute 1 for a zero divisor so the divider never sees /0; the
    // result is discarded at completion anyway.
    assign w_div_u  = w_b_zero ? 32'd1 : bus.B;
    assign w_quo_u  = bus.A / w_div_u;
    assign w_rem_u  = bus.A % w_div_u;

    // Signed divide via magnitudes: quotient sign = sign(A)^sign(B),
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 because negating 0x80000000 wraps.
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_div_s, w_quo_m, w_rem_m, w_quo_s, w_rem_s;
    assign w_a_neg = bus.A[31];
    assign w_b_neg = bus.B[31];
    assign w_a_mag = w_a_neg ? neg32(bus.A) : bus.A;
    assign w_b_mag = w_b_neg ? neg32(bus.B) : bus.B;
    assign w_div_s = w_b_zero ? 32'd1 : w_b_mag;
    assign w_quo_m = w_a_mag / w_div_s;
    assign w_rem_m = w_a_mag % w_div_s;
    assign w_quo_s = (w_a_neg ^ w_b_neg) ? neg32(w_quo_m) : w_quo_m;
    assign w_rem_s = w_a_neg ? neg32(w_rem_m) : w_rem_m;

    // ---------------- State register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    // ---------------- Next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_dz_nxt    = r_dz;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.XALUOp)
                        MULT: begin
                            {w_p_hi_nxt, w_p_lo_nxt} = w_prod_s;
                            w_dz_nxt    = 1'b0;
                            w_cnt_nxt   = LP_MULT_CNT;
                            w_state_nxt = RUN;
                        end
                        MULTU: begin
                            {w_p_hi_nxt, w_p_lo_nxt} = w_prod_u;
                            w_dz_nxt    = 1'b0;
                            w_cnt_nxt   = LP_MULT_CNT;
                            w_state_nxt = RUN;
                        end
                        DIV: begin
                            w_p_lo_nxt  = w_quo_s;
                            w_p_hi_nxt  = w_rem_s;
                            w_dz_nxt    = w_b_zero;
                            w_cnt_nxt   = LP_DIV_CNT;
                            w_state_nxt = RUN;
                        end
                        DIVU: begin
                            w_p_lo_nxt  = w_quo_u;
                            w_p_hi_nxt  = w_rem_u;
                            w_dz_nxt    = w_b_zero;
                            w_cnt_nxt   = LP_DIV_CNT;
                            w_state_nxt = RUN;
                        end
                        MTHI:    w_hi_nxt = bus.A;
                        MTLO:    w_lo_nxt = bus.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any start seen here is dropped; only the countdown advances.
                // "<= 1" also recovers from a counter that somehow reads 0.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (!r_dz) begin
                        w_hi_nxt = r_p_hi;
                        w_lo_nxt = r_p_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- Outputs ----------------
    logic [31:0] w_out;
    always_comb begin
        w_out = '0;
        if (bus.XALUOp == MFHI)
            w_out = r_hi;
        else if (bus.XALUOp == MFLO)
            w_out = r_lo;
    end

    assign bus.busy = (r_state == RUN);
    assign bus.out  = w_out;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule
